uart_prog_loader: RTL and testbench

- UART program loader: drives the memory upgrade port (upg_clk/upg_wen/upg_adr/upg_dat/upg_done) that instruction and data memories consume during programming mode.
- Receives an 8N1 byte stream from the host, parses a length header, assembles little-endian 32-bit words and issues one write pulse per word.
- Asserts done when the image is complete, handing memory back to the CPU ports.

---
 rtl/upg_pkg.sv | 28 ++
 rtl/uart_rx_byte.sv | 89 ++++++++
 rtl/uart_prog_loader.sv | 169 ++++++++++++++++
 tb/tb_uart_prog_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upg_pkg.sv
// Shared types and helpers for the UART program loader.
package upg_pkg;

    localparam int UPG_ADR_W = 15;
    localparam int UPG_DAT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } upg_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    function automatic int calc_cpb(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, mid-bit sampling, stop check.
module uart_rx_byte
    import upg_pkg::*;
#(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       byte_vld,
    output logic       frame_err
);

    localparam int CPB  = calc_cpb(CLK_HZ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_t     st_q, st_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          vld_q, ferr_q;
    logic          half_hit, full_hit, take_bit, take_stop;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            st_q   <= RX_IDLE;
        end else begin
            sync_q <= {sync_q[0], rx};
            st_q   <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            RX_IDLE:  if (!rx_s) st_d = RX_START;
            RX_START: if (half_hit) st_d = rx_s ? RX_IDLE : RX_BITS;
            RX_BITS:  if (full_hit && bit_q == 3'd7) st_d = RX_STOP;
            RX_STOP:  if (full_hit) st_d = RX_IDLE;
            default:  st_d = RX_IDLE;
        endcase
    end

    always_comb begin
        half_hit  = (cnt_q == CNT_HALF);
        full_hit  = (cnt_q == CNT_FULL);
        take_bit  = (st_q == RX_BITS) && full_hit;
        take_stop = (st_q == RX_STOP) && full_hit;
    end

    // The timer restarts on every state change so each phase counts from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            vld_q  <= take_stop & rx_s;
            ferr_q <= take_stop & ~rx_s;
            if (st_q == RX_IDLE || st_d != st_q || take_bit)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
            if (take_bit) begin
                sh_q  <= {rx_s, sh_q[7:1]};
                bit_q <= bit_q + 3'd1;
            end else if (st_q == RX_START) begin
                bit_q <= '0;
            end
        end
    end

    assign byte_o    = sh_q;
    assign byte_vld  = vld_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader driving the memory upgrade port.
// Define UPG_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_prog_loader
    import upg_pkg::*;
#(
    parameter int CLK_HZ    = 10_000_000,
    parameter int BAUD      = 115_200,
    parameter int MAX_WORDS = 32768
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_pg,
    input  logic                 rx,
    output logic                 upg_clk_o,
    output logic                 upg_wen_o,
    output logic [UPG_ADR_W-1:0] upg_adr_o,
    output logic [UPG_DAT_W-1:0] upg_dat_o,
    output logic                 upg_done_o,
    output logic                 upg_err_o,
    output logic                 busy_o
);

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    logic [7:0]           rx_byte;
    logic                 byte_vld, frame_err;
    upg_state_t           state_q, state_d;
    logic                 start_q, start_rise;
    logic [15:0]          len_q, wcnt_q, n_full;
    logic [UPG_ADR_W-1:0] adr_q;
    logic [UPG_DAT_W-1:0] dat_q;
    logic [1:0]           idx_q;
    logic                 wen_q;
    logic                 word_end, last_word;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]           csum_q;
`endif

    uart_rx_byte #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .byte_o   (rx_byte),
        .byte_vld (byte_vld),
        .frame_err(frame_err)
    );

    assign start_rise = start_pg & ~start_q;
    assign n_full     = {rx_byte, len_q[7:0]};
    assign word_end   = byte_vld && (idx_q == 2'd3);
    assign last_word  = (wcnt_q == len_q - 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // A restart edge overrides anything the receiver reports that cycle.
    always_comb begin
        state_d = state_q;
        if (start_rise) begin
            state_d = LEN_LO;
        end else begin
            unique case (state_q)
                LEN_LO: begin
                    if (frame_err)     state_d = ERR;
                    else if (byte_vld) state_d = LEN_HI;
                end
                LEN_HI: begin
                    if (frame_err) begin
                        state_d = ERR;
                    end else if (byte_vld) begin
                        if (n_full == 16'd0)           state_d = DONE;
                        else if ({1'b0, n_full} > MAX_N) state_d = ERR;
                        else                           state_d = DATA;
                    end
                end
                DATA: begin
                    if (frame_err) begin
                        state_d = ERR;
                    end else if (word_end && last_word) begin
`ifdef UPG_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end
                end
                CHK: begin
`ifdef UPG_CHECKSUM_EN
                    if (frame_err)     state_d = ERR;
                    else if (byte_vld) state_d = (rx_byte == csum_q) ? DONE : ERR;
`else
                    state_d = ERR;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_o     = 1'b0;
        upg_done_o = 1'b0;
        upg_err_o  = 1'b0;
        unique case (state_q)
            LEN_LO, LEN_HI, DATA, CHK: busy_o = 1'b1;
            DONE:    upg_done_o = 1'b1;
            ERR:     upg_err_o  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
            len_q   <= '0;
            wcnt_q  <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            idx_q   <= '0;
            wen_q   <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            start_q <= start_pg;
            wen_q   <= 1'b0;
            if (start_rise) begin
                adr_q  <= '0;
                idx_q  <= '0;
                wcnt_q <= '0;
`ifdef UPG_CHECKSUM_EN
                csum_q <= '0;
`endif
            end else begin
                // Address moves on only after the strobe cycle has been seen.
                if (wen_q) adr_q <= adr_q + 1'b1;
                if (byte_vld) begin
                    unique case (state_q)
                        LEN_LO: len_q[7:0]  <= rx_byte;
                        LEN_HI: len_q[15:8] <= rx_byte;
                        DATA: begin
                            dat_q[{idx_q, 3'b000} +: 8] <= rx_byte;
                            idx_q <= idx_q + 2'd1;
`ifdef UPG_CHECKSUM_EN
                            csum_q <= csum_q ^ rx_byte;
`endif
                            if (idx_q == 2'd3) begin
                                wen_q  <= 1'b1;
                                wcnt_q <= wcnt_q + 16'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign upg_clk_o = clk;
    assign upg_wen_o = wen_q;
    assign upg_adr_o = adr_q;
    assign upg_dat_o = dat_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench: table of host frames plus hand-written corner sequences.
module tb_uart_prog_loader;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 125_000;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef UPG_CHECKSUM_EN
    localparam int CSN = 1;
`else
    localparam int CSN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_pg = 1'b0;
    logic        rx = 1'b1;
    logic        upg_clk_o, upg_wen_o, upg_done_o, upg_err_o, busy_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;

    int checks = 0;
    int errors = 0;

    logic [14:0] wa[$];
    logic [31:0] wd[$];

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .MAX_WORDS(32768)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_pg  (start_pg),
        .rx        (rx),
        .upg_clk_o (upg_clk_o),
        .upg_wen_o (upg_wen_o),
        .upg_adr_o (upg_adr_o),
        .upg_dat_o (upg_dat_o),
        .upg_done_o(upg_done_o),
        .upg_err_o (upg_err_o),
        .busy_o    (busy_o)
    );

    always @(negedge clk) begin
        if (upg_wen_o === 1'b1) begin
            wa.push_back(upg_adr_o);
            wd.push_back(upg_dat_o);
        end
    end

    typedef struct {
        string       name;
        int          nb;
        int          bad;
        logic [7:0]  b[13];
        int          nw;
        logic [14:0] a[2];
        logic [31:0] d[2];
        logic        done;
        logic        err;
        logic        busy;
        logic [14:0] fadr;
    } vec_t;

    vec_t v[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_pg = 1'b1;
        tick(2);
        start_pg = 1'b0;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = ~bad;
        tick(CPB);
        rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        v[0] = '{"two_words", 10 + CSN, -1,
                 '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF,
                   8'hBE, 8'hAD, 8'hDE, 8'h2A, 8'h00, 8'h00},
                 2, '{15'h0000, 15'h0001}, '{32'h12345678, 32'hDEADBEEF},
                 1'b1, 1'b0, 1'b0, 15'd2};
        v[1] = '{"zero_len", 2, -1,
                 '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 0, '{15'h0, 15'h0}, '{32'h0, 32'h0},
                 1'b1, 1'b0, 1'b0, 15'd0};
        v[2] = '{"frame_err", 5, 4,
                 '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 0, '{15'h0, 15'h0}, '{32'h0, 32'h0},
                 1'b0, 1'b1, 1'b0, 15'd0};
        v[3] = '{"over_max", 2, -1,
                 '{8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 0, '{15'h0, 15'h0}, '{32'h0, 32'h0},
                 1'b0, 1'b1, 1'b0, 15'd0};
        v[4] = '{"at_max", 2, -1,
                 '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 0, '{15'h0, 15'h0}, '{32'h0, 32'h0},
                 1'b0, 1'b0, 1'b1, 15'd0};
        v[5] = '{"one_word", 6 + CSN, -1,
                 '{8'h01, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 1, '{15'h0000, 15'h0}, '{32'h3CC35AA5, 32'h0},
                 1'b1, 1'b0, 1'b0, 15'd1};

        tick(3);
        chk("rst_wen", 32'(upg_wen_o), 32'h0);
        chk("rst_adr", 32'(upg_adr_o), 32'h0);
        chk("rst_dat", upg_dat_o, 32'h0);
        chk("rst_done", 32'(upg_done_o), 32'h0);
        chk("rst_err", 32'(upg_err_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("upg_clk_hi", 32'(upg_clk_o), 32'h1);
        @(negedge clk);
        #1;
        chk("upg_clk_lo", 32'(upg_clk_o), 32'h0);
        rst = 1'b1;
        tick(4);
        chk("idle_busy", 32'(busy_o), 32'h0);

        for (int i = 0; i < 6; i++) begin
            wa.delete();
            wd.delete();
            pulse_start();
            chk({v[i].name, "_start_busy"}, 32'(busy_o), 32'h1);
            chk({v[i].name, "_start_err"}, 32'(upg_err_o), 32'h0);
            chk({v[i].name, "_start_done"}, 32'(upg_done_o), 32'h0);
            for (int j = 0; j < v[i].nb; j++)
                send_byte(v[i].b[j], j == v[i].bad);
            tick(20 * CPB);
            chk({v[i].name, "_nwr"}, 32'(wa.size()), 32'(v[i].nw));
            for (int k = 0; k < v[i].nw && k < wa.size(); k++) begin
                chk({v[i].name, "_adr"}, 32'(wa[k]), 32'(v[i].a[k]));
                chk({v[i].name, "_dat"}, wd[k], v[i].d[k]);
            end
            chk({v[i].name, "_done"}, 32'(upg_done_o), 32'(v[i].done));
            chk({v[i].name, "_err"}, 32'(upg_err_o), 32'(v[i].err));
            chk({v[i].name, "_busy"}, 32'(busy_o), 32'(v[i].busy));
            chk({v[i].name, "_fadr"}, 32'(upg_adr_o), 32'(v[i].fadr));
        end

        // Data-memory address: counter preset to 0x4000, glitch before header.
        wa.delete();
        wd.delete();
        pulse_start();
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(CPB);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        force dut.adr_q = 15'h4000;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        if (CSN == 1) send_byte(8'h04, 1'b0);
        tick(20 * CPB);
        chk("dmem_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() > 0) begin
            chk("dmem_adr", 32'(wa[0]), 32'h4000);
            chk("dmem_dat", wd[0], 32'h04030201);
        end
        chk("dmem_done", 32'(upg_done_o), 32'h1);
        release dut.adr_q;

        // Abort after two data bytes, then a fresh one-word frame.
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        pulse_start();
        chk("abort_busy", 32'(busy_o), 32'h1);
        chk("abort_adr0", 32'(upg_adr_o), 32'h0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        if (CSN == 1) send_byte(8'h01, 1'b0);
        tick(20 * CPB);
        chk("abort_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() > 0) begin
            chk("abort_adr", 32'(wa[0]), 32'h0);
            chk("abort_dat", wd[0], 32'h00000001);
        end
        chk("abort_done", 32'(upg_done_o), 32'h1);

        // Asynchronous reset in the middle of a word.
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        rst = 1'b0;
        #1;
        chk("arst_wen", 32'(upg_wen_o), 32'h0);
        chk("arst_adr", 32'(upg_adr_o), 32'h0);
        chk("arst_dat", upg_dat_o, 32'h0);
        chk("arst_busy", 32'(busy_o), 32'h0);
        chk("arst_done", 32'(upg_done_o), 32'h0);
        chk("arst_err", 32'(upg_err_o), 32'h0);
        tick(2);
        rst = 1'b1;
        send_byte(8'hDD, 1'b0);
        tick(20 * CPB);
        chk("arst_nwr", 32'(wa.size()), 32'd0);
        chk("arst_busy2", 32'(busy_o), 32'h0);
        chk("arst_done2", 32'(upg_done_o), 32'h0);

`ifdef UPG_CHECKSUM_EN
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h44, 1'b0);
        tick(20 * CPB);
        chk("csum_ok_done", 32'(upg_done_o), 32'h1);
        chk("csum_ok_nwr", 32'(wa.size()), 32'd1);
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h45, 1'b0);
        tick(20 * CPB);
        chk("csum_bad_err", 32'(upg_err_o), 32'h1);
        chk("csum_bad_done", 32'(upg_done_o), 32'h0);
        chk("csum_bad_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() > 0) chk("csum_bad_dat", wd[0], 32'h44332211);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
